// File: rtl/registrador_pkg.sv
// Shared mode codes, FSM states and helpers for the universal register.
package registrador_pkg;

    localparam logic [2:0] MODO_HOLD = 3'b000;
    localparam logic [2:0] MODO_LOAD = 3'b001;
    localparam logic [2:0] MODO_SHL  = 3'b010;
    localparam logic [2:0] MODO_SHR  = 3'b011;
    localparam logic [2:0] MODO_ROL  = 3'b100;
    localparam logic [2:0] MODO_ROR  = 3'b101;
    localparam logic [2:0] MODO_INC  = 3'b110;
    localparam logic [2:0] MODO_DEC  = 3'b111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } estado_t;

    function automatic logic eh_deslocamento(input logic [2:0] m);
        return (m == MODO_SHL) || (m == MODO_SHR) || (m == MODO_ROL) || (m == MODO_ROR);
    endfunction

endpackage

// File: rtl/registrador_generico.sv
// W-bit storage register with asynchronous active-high reset and load enable.
module registrador_generico #(
    parameter int             W         = 8,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_q <= RESET_VAL;
        else if (en)
            r_q <= d;
    end

    assign q = r_q;

endmodule

// File: rtl/registrador_universal.sv
// Universal W-bit register: load, multi-cycle shift/rotate, inc/dec with
// start/busy/done handshake.
module registrador_universal
    import registrador_pkg::*;
#(
    parameter int           W         = 8,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [W-1:0]           entrada,
    input  logic [2:0]             modo,
    input  logic                   inicio,
    input  logic [$clog2(W+1)-1:0] qtd,
    input  logic                   serial_in,
    output logic [W-1:0]           saida,
    output logic                   serial_out,
    output logic                   vai_um,
    output logic                   zero,
    output logic                   ocupado,
    output logic                   pronto
);

    localparam int CW = $clog2(W+1);

    estado_t       r_estado, w_prox_estado;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_modo;
    logic          r_pronto;
    logic          r_serial_out;
    logic          r_vai_um;

    logic [W-1:0]  w_saida;
    logic [W-1:0]  w_d;
    logic          w_en;
    logic [CW-1:0] w_n;
    logic          w_aceita;
    logic          w_inicia_desl;
    logic          w_ultimo;

    registrador_generico #(
        .W         (W),
        .RESET_VAL (RESET_VAL)
    ) u_armazenamento (
        .clock (clock),
        .reset (reset),
        .en    (w_en),
        .d     (w_d),
        .q     (w_saida)
    );

    // Amounts beyond W are clamped so a full rotate is the longest operation.
    assign w_n           = (qtd > CW'(W)) ? CW'(W) : qtd;
    assign w_aceita      = inicio && (r_estado == ST_IDLE);
    assign w_inicia_desl = w_aceita && eh_deslocamento(modo) && (w_n != '0);
    assign w_ultimo      = (r_estado == ST_SHIFT) && (r_cnt == CW'(1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_estado <= ST_IDLE;
        else
            r_estado <= w_prox_estado;
    end

    always_comb begin
        w_prox_estado = r_estado;
        case (r_estado)
            ST_IDLE:  if (w_inicia_desl) w_prox_estado = ST_SHIFT;
            ST_SHIFT: if (w_ultimo)      w_prox_estado = ST_IDLE;
            default:  w_prox_estado = ST_IDLE;
        endcase
    end

    always_comb begin
        ocupado    = (r_estado == ST_SHIFT);
        pronto     = r_pronto;
        serial_out = r_serial_out;
        vai_um     = r_vai_um;
        saida      = w_saida;
        zero       = (w_saida == '0);
    end

    always_comb begin
        w_d  = w_saida;
        w_en = 1'b0;
        if (r_estado == ST_SHIFT) begin
            w_en = 1'b1;
            case (r_modo)
                MODO_SHL: w_d = {w_saida[W-2:0], serial_in};
                MODO_SHR: w_d = {serial_in, w_saida[W-1:1]};
                MODO_ROL: w_d = {w_saida[W-2:0], w_saida[W-1]};
                MODO_ROR: w_d = {w_saida[0], w_saida[W-1:1]};
                default:  w_en = 1'b0;
            endcase
        end else if (w_aceita) begin
            case (modo)
                MODO_LOAD: begin w_d = entrada;          w_en = 1'b1; end
                MODO_INC:  begin w_d = w_saida + W'(1);  w_en = 1'b1; end
                MODO_DEC:  begin w_d = w_saida - W'(1);  w_en = 1'b1; end
                default:   w_en = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt        <= '0;
            r_modo       <= MODO_HOLD;
            r_pronto     <= 1'b0;
            r_serial_out <= 1'b0;
            r_vai_um     <= 1'b0;
        end else begin
            r_pronto <= (w_aceita && !w_inicia_desl) || w_ultimo;
            if (w_inicia_desl) begin
                r_cnt  <= w_n;
                r_modo <= modo;
            end else if (r_estado == ST_SHIFT) begin
                r_cnt <= r_cnt - CW'(1);
            end
            if (r_estado == ST_SHIFT) begin
                if (r_modo == MODO_SHL)
                    r_serial_out <= w_saida[W-1];
                else if (r_modo == MODO_SHR)
                    r_serial_out <= w_saida[0];
            end
            if (w_aceita && (modo == MODO_INC))
                r_vai_um <= (w_saida == '1);
            else if (w_aceita && (modo == MODO_DEC))
                r_vai_um <= (w_saida == '0);
        end
    end

endmodule

// File: tb/tb_registrador_universal.sv
// Directed self-checking bench for registrador_universal (W=8, RESET_VAL=0).
module tb_registrador_universal;

    logic       clock;
    logic       reset;
    logic [7:0] entrada;
    logic [2:0] modo;
    logic       inicio;
    logic [3:0] qtd;
    logic       serial_in;
    logic [7:0] saida;
    logic       serial_out;
    logic       vai_um;
    logic       zero;
    logic       ocupado;
    logic       pronto;

    int n_pass;
    int n_total;

    registrador_universal #(
        .W         (8),
        .RESET_VAL (8'h00)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .entrada    (entrada),
        .modo       (modo),
        .inicio     (inicio),
        .qtd        (qtd),
        .serial_in  (serial_in),
        .saida      (saida),
        .serial_out (serial_out),
        .vai_um     (vai_um),
        .zero       (zero),
        .ocupado    (ocupado),
        .pronto     (pronto)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic cmd(input logic [2:0] m, input logic [7:0] d, input logic [3:0] q);
        modo    = m;
        entrada = d;
        qtd     = q;
        inicio  = 1'b1;
        tick();
        inicio  = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; inicio = 1'b0; modo = 3'b000; entrada = 8'h00; qtd = 4'd0; serial_in = 1'b0;
        #2;
        if (saida !== 8'h00) $display("FAIL rst_saida: got %h want 00", saida); else n_pass++;
        n_total++;
        if (ocupado !== 1'b0 || pronto !== 1'b0) $display("FAIL rst_flags: ocupado=%b pronto=%b want 0 0", ocupado, pronto); else n_pass++;
        n_total++;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_run;
        cmd(3'b111, 8'h00, 4'd0);
        if (saida !== 8'hFF || vai_um !== 1'b1) $display("FAIL mid_dec: saida=%h vai_um=%b want ff 1", saida, vai_um); else n_pass++;
        n_total++;
        serial_in = 1'b0;
        cmd(3'b010, 8'h00, 4'd4);
        tick();
        if (saida !== 8'hFE || serial_out !== 1'b1 || ocupado !== 1'b1) $display("FAIL mid_step1: saida=%h so=%b ocupado=%b want fe 1 1", saida, serial_out, ocupado); else n_pass++;
        n_total++;
        #2 reset = 1'b1;
        #1;
        if (saida !== 8'h00 || ocupado !== 1'b0 || pronto !== 1'b0 || serial_out !== 1'b0 || vai_um !== 1'b0 || zero !== 1'b1)
            $display("FAIL mid_reset: saida=%h oc=%b pr=%b so=%b vu=%b z=%b want 00 0 0 0 0 1", saida, ocupado, pronto, serial_out, vai_um, zero);
        else n_pass++;
        n_total++;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_load;
        cmd(3'b001, 8'hA5, 4'd0);
        if (saida !== 8'hA5 || pronto !== 1'b1 || ocupado !== 1'b0) $display("FAIL load: saida=%h pr=%b oc=%b want a5 1 0", saida, pronto, ocupado); else n_pass++;
        n_total++;
        tick();
        if (pronto !== 1'b0 || ocupado !== 1'b0) $display("FAIL load_pulse: pr=%b oc=%b want 0 0", pronto, ocupado); else n_pass++;
        n_total++;
    endtask

    task automatic test_shl;
        serial_in = 1'b1;
        cmd(3'b010, 8'h00, 4'd3);
        if (ocupado !== 1'b1 || pronto !== 1'b0 || saida !== 8'hA5) $display("FAIL shl_accept: oc=%b pr=%b saida=%h want 1 0 a5", ocupado, pronto, saida); else n_pass++;
        n_total++;
        modo = 3'b001; entrada = 8'h00; inicio = 1'b1;
        tick();
        if (saida !== 8'h4B || serial_out !== 1'b1 || pronto !== 1'b0 || ocupado !== 1'b1) $display("FAIL shl_s1: saida=%h so=%b pr=%b oc=%b want 4b 1 0 1", saida, serial_out, pronto, ocupado); else n_pass++;
        n_total++;
        tick();
        if (saida !== 8'h97 || serial_out !== 1'b0 || pronto !== 1'b0 || ocupado !== 1'b1) $display("FAIL shl_s2: saida=%h so=%b pr=%b oc=%b want 97 0 0 1", saida, serial_out, pronto, ocupado); else n_pass++;
        n_total++;
        inicio = 1'b0;
        tick();
        if (saida !== 8'h2F || serial_out !== 1'b1 || pronto !== 1'b1 || ocupado !== 1'b0) $display("FAIL shl_s3: saida=%h so=%b pr=%b oc=%b want 2f 1 1 0", saida, serial_out, pronto, ocupado); else n_pass++;
        n_total++;
        tick();
        if (saida !== 8'h2F || pronto !== 1'b0) $display("FAIL shl_after: saida=%h pr=%b want 2f 0", saida, pronto); else n_pass++;
        n_total++;
    endtask

    task automatic test_rotate;
        int n;
        cmd(3'b001, 8'h81, 4'd0);
        tick();
        cmd(3'b101, 8'h00, 4'd8);
        tick();
        if (saida !== 8'hC0) $display("FAIL ror_s1: saida=%h want c0", saida); else n_pass++;
        n_total++;
        n = 1;
        while (ocupado && n < 20) begin tick(); n++; end
        if (n !== 8 || saida !== 8'h81 || pronto !== 1'b1) $display("FAIL ror8: steps=%0d saida=%h pr=%b want 8 81 1", n, saida, pronto); else n_pass++;
        n_total++;
        tick();
        cmd(3'b101, 8'h00, 4'd12);
        n = 0;
        while (ocupado && n < 20) begin tick(); n++; end
        if (n !== 8 || saida !== 8'h81) $display("FAIL ror12_clamp: busy=%0d saida=%h want 8 81", n, saida); else n_pass++;
        n_total++;
        tick();
        cmd(3'b101, 8'h00, 4'd0);
        if (pronto !== 1'b1 || ocupado !== 1'b0 || saida !== 8'h81) $display("FAIL ror0: pr=%b oc=%b saida=%h want 1 0 81", pronto, ocupado, saida); else n_pass++;
        n_total++;
        tick();
    endtask

    task automatic test_incdec;
        cmd(3'b001, 8'hFF, 4'd0);
        tick();
        cmd(3'b110, 8'h00, 4'd0);
        if (saida !== 8'h00 || vai_um !== 1'b1 || zero !== 1'b1) $display("FAIL inc_ff: saida=%h vu=%b z=%b want 00 1 1", saida, vai_um, zero); else n_pass++;
        n_total++;
        tick();
        cmd(3'b111, 8'h00, 4'd0);
        if (saida !== 8'hFF || vai_um !== 1'b1 || zero !== 1'b0) $display("FAIL dec_00: saida=%h vu=%b z=%b want ff 1 0", saida, vai_um, zero); else n_pass++;
        n_total++;
        tick();
        cmd(3'b001, 8'h10, 4'd0);
        if (vai_um !== 1'b1) $display("FAIL load_keeps_carry: vu=%b want 1", vai_um); else n_pass++;
        n_total++;
        tick();
        cmd(3'b110, 8'h00, 4'd0);
        if (saida !== 8'h11 || vai_um !== 1'b0) $display("FAIL inc_10: saida=%h vu=%b want 11 0", saida, vai_um); else n_pass++;
        n_total++;
        tick();
    endtask

    task automatic test_reset_abort;
        cmd(3'b001, 8'hF0, 4'd0);
        tick();
        serial_in = 1'b0;
        cmd(3'b011, 8'h00, 4'd5);
        tick();
        tick();
        if (saida !== 8'h3C || serial_out !== 1'b0) $display("FAIL shr_s2: saida=%h so=%b want 3c 0", saida, serial_out); else n_pass++;
        n_total++;
        #2 reset = 1'b1;
        #1;
        if (saida !== 8'h00 || ocupado !== 1'b0 || pronto !== 1'b0) $display("FAIL abort_reset: saida=%h oc=%b pr=%b want 00 0 0", saida, ocupado, pronto); else n_pass++;
        n_total++;
        tick();
        if (pronto !== 1'b0 || ocupado !== 1'b0) $display("FAIL abort_hold: pr=%b oc=%b want 0 0", pronto, ocupado); else n_pass++;
        n_total++;
        reset = 1'b0;
        tick();
        cmd(3'b001, 8'h5A, 4'd0);
        if (saida !== 8'h5A || pronto !== 1'b1 || ocupado !== 1'b0) $display("FAIL after_abort: saida=%h pr=%b oc=%b want 5a 1 0", saida, pronto, ocupado); else n_pass++;
        n_total++;
        tick();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_reset_mid_run();
        test_load();
        test_shl();
        test_rotate();
        test_incdec();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
